bist_pattern_ctrl: RTL and testbench



---
 rtl/bist_pattern_ctrl.sv | 88 ++++++++
 tb/tb_bist_pattern_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_pattern_ctrl.sv
// BIST controller: 6-bit LFSR pattern source and 8-bit MISR compactor for a 6-in/2-out CUT.
// Latency: one pattern per cycle, verdict registered on the edge that absorbs the last response (NUM_PAT cycles).
// Backpressure: none; start is honoured in IDLE/DONE only, and resp_in is assumed valid throughout RUN.
module bist_pattern_ctrl #(
    parameter int         NUM_PAT = 63,
    parameter logic [5:0] SEED    = 6'h01,
    parameter logic [7:0] GOLDEN  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [5:0] pat_out,
    input  logic [1:0] resp_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] LAST = 6'(NUM_PAT - 1);

    state_t     state;
    logic [5:0] lfsr;
    logic [7:0] misr;
    logic [5:0] cnt;
    logic [5:0] lfsr_next;
    logic [7:0] misr_next;
    logic       fb;

    // x^6 + x^5 + 1 Fibonacci; maximal length, so any nonzero seed visits all 63 states
    assign lfsr_next = {lfsr[4:0], lfsr[5] ^ lfsr[4]};

    // x^8 + x^4 + x^3 + x^2 + 1 Galois, s2 enters at bit 0 and s1 at bit 1
    assign fb        = misr[7];
    assign misr_next = {misr[6], misr[5], misr[4],
                        misr[3] ^ fb, misr[2] ^ fb, misr[1] ^ fb,
                        misr[0] ^ resp_in[1], fb ^ resp_in[0]};

    assign pat_out   = lfsr;
    assign signature = misr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lfsr  <= SEED;
            misr  <= 8'h00;
            cnt   <= 6'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        lfsr  <= SEED;
                        misr  <= 8'h00;
                        cnt   <= 6'd0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                RUN: begin
                    misr <= misr_next;
                    lfsr <= lfsr_next;
                    cnt  <= cnt + 6'd1;
                    // Verdict uses misr_next so the final response is included
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (misr_next == GOLDEN);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Directed bench for bist_pattern_ctrl: vector table for LFSR/MISR stepping plus hand sequences for
// run length, restart, freeze, short runs, real-CUT golden/fault runs and asynchronous reset.
module tb_bist_pattern_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Example benchmark CUT: a..f = pat[5:0]; s1 = ab | (c^d), s2 = (e^f) | (a & ~c)
    function automatic logic [1:0] cut_fn(input logic [5:0] p, input logic sa0);
        logic s1;
        logic s2;
        s1 = ((p[5] & p[4]) | (p[3] ^ p[2])) & ~sa0;
        s2 = (p[1] ^ p[0]) | (p[5] & ~p[3]);
        return {s1, s2};
    endfunction

    // Reference signature of a full 63-pattern run from seed 01
    function automatic logic [7:0] model_sig(input logic sa0);
        logic [5:0] l;
        logic [7:0] m;
        logic [1:0] r;
        logic       f;
        l = 6'h01;
        m = 8'h00;
        for (int i = 0; i < 63; i++) begin
            r = cut_fn(l, sa0);
            f = m[7];
            m = {m[6:4], m[3] ^ f, m[2] ^ f, m[1] ^ f, m[0] ^ r[1], f ^ r[0]};
            l = {l[4:0], l[5] ^ l[4]};
        end
        return m;
    endfunction

    localparam logic [7:0] CUT_GOLDEN = model_sig(1'b0);

    // Main instance: defaults, response driven directly by the bench
    logic       start_main = 1'b0;
    logic [1:0] resp_main  = 2'b00;
    logic [5:0] pat_main;
    logic       busy_main, done_main, pass_main;
    logic [7:0] sig_main;

    bist_pattern_ctrl u_main (
        .clk(clk), .rst_n(rst_n), .start(start_main), .pat_out(pat_main), .resp_in(resp_main),
        .busy(busy_main), .done(done_main), .pass(pass_main), .signature(sig_main));

    // Short runs: NUM_PAT=3 with constant response 01, and NUM_PAT=1
    logic       start_aux = 1'b0;
    logic [5:0] pat_k7, pat_k6, pat_one;
    logic       busy_k7, done_k7, pass_k7;
    logic       busy_k6, done_k6, pass_k6;
    logic       busy_one, done_one, pass_one;
    logic [7:0] sig_k7, sig_k6, sig_one;

    bist_pattern_ctrl #(.NUM_PAT(3), .SEED(6'h01), .GOLDEN(8'h07)) u_k7 (
        .clk(clk), .rst_n(rst_n), .start(start_aux), .pat_out(pat_k7), .resp_in(2'b01),
        .busy(busy_k7), .done(done_k7), .pass(pass_k7), .signature(sig_k7));

    bist_pattern_ctrl #(.NUM_PAT(3), .SEED(6'h01), .GOLDEN(8'h06)) u_k6 (
        .clk(clk), .rst_n(rst_n), .start(start_aux), .pat_out(pat_k6), .resp_in(2'b01),
        .busy(busy_k6), .done(done_k6), .pass(pass_k6), .signature(sig_k6));

    bist_pattern_ctrl #(.NUM_PAT(1), .SEED(6'h05), .GOLDEN(8'h02)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start_aux), .pat_out(pat_one), .resp_in(2'b10),
        .busy(busy_one), .done(done_one), .pass(pass_one), .signature(sig_one));

    // Real CUT attached, with optional s1 stuck-at-0
    logic       start_cut = 1'b0;
    logic       fault_sa0 = 1'b0;
    logic [5:0] pat_cut;
    logic [1:0] resp_cut;
    logic       busy_cut, done_cut, pass_cut;
    logic [7:0] sig_cut;

    assign resp_cut = cut_fn(pat_cut, fault_sa0);

    bist_pattern_ctrl #(.NUM_PAT(63), .SEED(6'h01), .GOLDEN(CUT_GOLDEN)) u_cut (
        .clk(clk), .rst_n(rst_n), .start(start_cut), .pat_out(pat_cut), .resp_in(resp_cut),
        .busy(busy_cut), .done(done_cut), .pass(pass_cut), .signature(sig_cut));

    typedef struct {
        logic       st;
        logic [1:0] resp;
        logic [5:0] pat;
        logic [7:0] sig;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] seen;
        int          n;
        int          uniq;

        // {start, resp applied, pat_out before edge, signature after edge}; start mid-run at step 3
        tbl[0] = '{1'b0, 2'b11, 6'h01, 8'h03};
        tbl[1] = '{1'b0, 2'b11, 6'h02, 8'h05};
        tbl[2] = '{1'b0, 2'b01, 6'h04, 8'h0B};
        tbl[3] = '{1'b1, 2'b10, 6'h08, 8'h14};
        tbl[4] = '{1'b0, 2'b11, 6'h10, 8'h2B};
        tbl[5] = '{1'b0, 2'b00, 6'h21, 8'h56};
        tbl[6] = '{1'b0, 2'b01, 6'h03, 8'hAD};
        tbl[7] = '{1'b0, 2'b11, 6'h06, 8'h44};

        #12;
        chk("rst_busy", 32'(busy_main), 32'd0);
        chk("rst_done", 32'(done_main), 32'd0);
        chk("rst_pass", 32'(pass_main), 32'd0);
        chk("rst_pat",  32'(pat_main),  32'h01);
        chk("rst_sig",  32'(sig_main),  32'h00);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_hold_busy", 32'(busy_main), 32'd0);

        // Run 1: vector table, then zero response to the end
        start_main = 1'b1;
        tick();
        start_main = 1'b0;
        chk("run1_busy", 32'(busy_main), 32'd1);
        for (int i = 0; i < 8; i++) begin
            start_main = tbl[i].st;
            resp_main  = tbl[i].resp;
            chk($sformatf("tbl%0d_pat", i), 32'(pat_main), 32'(tbl[i].pat));
            tick();
            start_main = 1'b0;
            chk($sformatf("tbl%0d_sig", i), 32'(sig_main), 32'(tbl[i].sig));
        end
        resp_main = 2'b00;
        n = 8;
        while (busy_main && n < 100) begin
            tick();
            n++;
        end
        chk("run1_len",  32'(n), 32'd63);
        chk("run1_done", 32'(done_main), 32'd1);

        // Run 2: restart from DONE, zero response, every nonzero pattern exactly once
        start_main = 1'b1;
        tick();
        start_main = 1'b0;
        chk("restart_busy", 32'(busy_main), 32'd1);
        chk("restart_done", 32'(done_main), 32'd0);
        chk("restart_pat",  32'(pat_main),  32'h01);
        chk("restart_sig",  32'(sig_main),  32'h00);
        seen = '0;
        n = 0;
        while (busy_main && n < 100) begin
            seen[pat_main] = 1'b1;
            tick();
            n++;
        end
        uniq = 0;
        for (int i = 1; i < 64; i++) if (seen[i]) uniq++;
        chk("run2_len",    32'(n), 32'd63);
        chk("run2_uniq",   32'(uniq), 32'd63);
        chk("zero_done",   32'(done_main), 32'd1);
        chk("zero_pass",   32'(pass_main), 32'd1);
        chk("zero_sig",    32'(sig_main),  32'h00);

        // DONE freezes outputs even with a changing response
        resp_main = 2'b11;
        tick();
        tick();
        tick();
        chk("frz_sig",  32'(sig_main),  32'h00);
        chk("frz_pat",  32'(pat_main),  32'h01);
        chk("frz_pass", 32'(pass_main), 32'd1);
        chk("frz_done", 32'(done_main), 32'd1);
        resp_main = 2'b00;

        // Short runs
        start_aux = 1'b1;
        tick();
        start_aux = 1'b0;
        chk("one_pat",  32'(pat_one), 32'h05);
        chk("k7_pat0",  32'(pat_k7),  32'h01);
        tick();
        chk("k7_sig0",  32'(sig_k7),  32'h01);
        chk("one_done", 32'(done_one), 32'd1);
        chk("one_busy", 32'(busy_one), 32'd0);
        chk("one_sig",  32'(sig_one),  32'h02);
        chk("one_pass", 32'(pass_one), 32'd1);
        tick();
        chk("k7_sig1",  32'(sig_k7),  32'h03);
        chk("k7_pass_early", 32'(pass_k7), 32'd0);
        chk("k7_busy_mid",   32'(busy_k7), 32'd1);
        tick();
        chk("k7_sig2",  32'(sig_k7),  32'h07);
        chk("k7_done",  32'(done_k7), 32'd1);
        chk("k7_pass",  32'(pass_k7), 32'd1);
        chk("k6_sig",   32'(sig_k6),  32'h07);
        chk("k6_pass",  32'(pass_k6), 32'd0);

        // Real CUT, fault-free then s1 stuck-at-0
        start_cut = 1'b1;
        tick();
        start_cut = 1'b0;
        n = 0;
        while (!done_cut && n < 100) begin
            tick();
            n++;
        end
        chk("cut_len",  32'(n), 32'd63);
        chk("cut_sig",  32'(sig_cut),  32'(CUT_GOLDEN));
        chk("cut_pass", 32'(pass_cut), 32'd1);
        fault_sa0 = 1'b1;
        start_cut = 1'b1;
        tick();
        start_cut = 1'b0;
        n = 0;
        while (!done_cut && n < 100) begin
            tick();
            n++;
        end
        chk("sa0_done", 32'(done_cut), 32'd1);
        chk("sa0_sig",  32'(sig_cut),  32'(model_sig(1'b1)));
        chk("sa0_pass", 32'(pass_cut), 32'd0);
        fault_sa0 = 1'b0;

        // Asynchronous reset between edges in the middle of a run
        start_main = 1'b1;
        resp_main  = 2'b11;
        tick();
        start_main = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_arst_busy", 32'(busy_main), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_main), 32'd0);
        chk("arst_pat",  32'(pat_main),  32'h01);
        chk("arst_sig",  32'(sig_main),  32'h00);
        chk("arst_done", 32'(done_main), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_idle", 32'(busy_main), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
